// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues decoded commands and serialises them through the ALU and uart_tx
module cmd_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT_CYC  = 4096,
  parameter int BUSY_ACK_CYC = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid,
  input  logic [1:0]                        cmd_opcode,
  input  logic [2:0]                        cmd_op1,
  input  logic [2:0]                        cmd_op2,
  output logic                              cmd_ready,
  output logic                              alu_start,
  output logic [1:0]                        alu_opcode,
  output logic [2:0]                        alu_a,
  output logic [2:0]                        alu_b,
  input  logic                              alu_done,
  input  logic [7:0]                        alu_result,
  output logic                              tx_start,
  output logic [7:0]                        tx_data,
  input  logic                              tx_busy,
  output logic [7:0]                        result,
  output logic                              result_valid,
  output logic                              err_timeout,
  output logic [7:0]                        drop_cnt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ALU, TX_REQ, TX_ACK, TX_DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_q_op [FIFO_DEPTH];
  logic [2:0] r_q_a [FIFO_DEPTH];
  logic [2:0] r_q_b [FIFO_DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [TW-1:0] r_tmo;
  logic [LW-1:0] w_level_nx;
  logic w_full, w_pop, w_push, w_drop, w_wait, w_sat, w_expire, w_abort;
  always_comb begin
    w_full     = fifo_level == LW'(FIFO_DEPTH);
    w_pop      = r_state == IDLE && fifo_level != '0;
    w_push     = cmd_valid && (!w_full || w_pop);
    w_drop     = cmd_valid && w_full && !w_pop;
    w_level_nx = fifo_level + LW'(w_push) - LW'(w_pop);
    w_wait     = r_state inside {WAIT_ALU, TX_REQ, TX_ACK, TX_DONE};
    w_sat      = (r_state == WAIT_ALU && alu_done) || (r_state == TX_REQ && !tx_busy) ||
                 (r_state == TX_ACK && tx_busy) || (r_state == TX_DONE && !tx_busy);
    // the acknowledge wait has its own, much shorter, limit
    w_expire   = r_tmo == (r_state == TX_ACK ? TW'(BUSY_ACK_CYC - 1) : TW'(TIMEOUT_CYC - 1));
    w_abort    = w_wait && !w_sat && w_expire;
    w_next     = r_state;
    case (r_state)
      IDLE:     w_next = w_pop ? ISSUE : IDLE;
      ISSUE:    w_next = WAIT_ALU;
      WAIT_ALU: w_next = alu_done ? TX_REQ : WAIT_ALU;
      TX_REQ:   w_next = tx_busy ? TX_REQ : TX_ACK;
      TX_ACK:   w_next = tx_busy ? TX_DONE : TX_ACK;
      TX_DONE:  w_next = tx_busy ? TX_DONE : IDLE;
      default:  w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_op[r_wr] <= cmd_opcode;
      r_q_a[r_wr]  <= cmd_op1;
      r_q_b[r_wr]  <= cmd_op2;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_tmo        <= '0;
      fifo_level   <= '0;
      cmd_ready    <= 1'b1;
      drop_cnt     <= '0;
      alu_start    <= 1'b0;
      alu_opcode   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      r_wr         <= r_wr + PW'(w_push);
      r_rd         <= r_rd + PW'(w_pop);
      r_tmo        <= w_next != r_state ? '0 : r_tmo + TW'(w_wait);
      fifo_level   <= w_level_nx;
      cmd_ready    <= w_level_nx != LW'(FIFO_DEPTH);
      drop_cnt     <= drop_cnt + 8'(w_drop && drop_cnt != 8'hff);
      alu_start    <= w_pop;
      if (w_pop) begin
        alu_opcode <= r_q_op[r_rd];
        alu_a      <= r_q_a[r_rd];
        alu_b      <= r_q_b[r_rd];
      end
      result_valid <= r_state == WAIT_ALU && alu_done;
      if (r_state == WAIT_ALU && alu_done) begin
        result     <= alu_result;
        tx_data    <= alu_result;
      end
      tx_start     <= r_state == TX_REQ && !tx_busy;
      err_timeout  <= err_timeout || w_abort;
    end
  end
endmodule
